// File: rtl/knn_local_mem_1r1w_pipe.sv
// knn_local_mem_1r1w_pipe
// ----------------------------------------------------------------------------
// Simple-dual-port local buffer for the partialKnn kernels: one read port and
// one write port per cycle, a configurable read pipeline, and per-lane write
// enables on the write port.
//
// Ports
//   clk       clock
//   reset     asynchronous, active-high reset (clears read pipeline and q0)
//   address0  read address
//   ce0       read request, sampled on the rising clk edge
//   q0        read data, holds its value between completing reads
//   q0_valid  one-cycle strobe marking new q0 data
//   address1  write address
//   ce1       write port enable
//   we1       per-lane write enable, lane i = bits [i*LaneWidth +: LaneWidth]
//   d1        write data
//
// Handshake: the read port has no ready. A request (ce0=1 at an edge) always
// completes exactly ReadLatency edges later with q0_valid=1 for one cycle;
// the consumer must take every strobe. The write port is fire-and-forget.
//
// Timing: read sampled at edge t -> q0/q0_valid update at edge t+ReadLatency.
// Stage 0 captures the array word at edge t, stages 1..ReadLatency-1 carry it
// forward, and the q0 output register takes the last stage at edge t+L.
//
// Collision (same edge, same in-range address, both ports active): Bypass=0
// returns the pre-write word, Bypass=1 returns the merged post-write word.
// Out-of-range reads complete normally with zero data; out-of-range writes
// are dropped. Array contents are not reset; writes are blocked during reset.
// ----------------------------------------------------------------------------
module knn_local_mem_1r1w_pipe #(
  parameter int DataWidth    = 256,
  parameter int AddressRange = 2048,
  parameter int AddressWidth = 11,
  parameter int LaneWidth    = 32,
  parameter int ReadLatency  = 2,
  parameter int Bypass       = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [AddressWidth-1:0]           address0,
  input  logic                              ce0,
  output logic [DataWidth-1:0]              q0,
  output logic                              q0_valid,
  input  logic [AddressWidth-1:0]           address1,
  input  logic                              ce1,
  input  logic [DataWidth/LaneWidth-1:0]    we1,
  input  logic [DataWidth-1:0]              d1
);

  localparam int Lanes = DataWidth / LaneWidth;
  // One extra bit so AddressRange == 2^AddressWidth still compares correctly.
  localparam logic [AddressWidth:0] AddrLimit = (AddressWidth + 1)'(AddressRange);

  logic [DataWidth-1:0] mem [AddressRange];

  logic                 rd_in_range;
  logic                 wr_in_range;
  logic                 wr_active;
  logic                 collide;
  logic [DataWidth-1:0] rd_word;
  logic [DataWidth-1:0] merged_word;
  logic [DataWidth-1:0] sample_word;

  logic [DataWidth-1:0] stage_data [ReadLatency];
  logic [ReadLatency-1:0] stage_valid;

  assign rd_in_range = ({1'b0, address0} < AddrLimit);
  assign wr_in_range = ({1'b0, address1} < AddrLimit);
  // Reset is sampled as a level here so writes are blocked while it is held.
  assign wr_active   = ce1 && !reset && wr_in_range;
  // Equal addresses with an in-range read imply an in-range write as well.
  assign collide     = wr_active && ce0 && rd_in_range && (address0 == address1);

  // Old array word; out-of-range reads see zero instead of an aliased word.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[address0];
    end
  end

  // Post-write view of the addressed word: enabled lanes take d1.
  always_comb begin
    merged_word = rd_word;
    for (int i = 0; i < Lanes; i++) begin
      if (we1[i]) begin
        merged_word[i*LaneWidth +: LaneWidth] = d1[i*LaneWidth +: LaneWidth];
      end
    end
  end

  always_comb begin
    sample_word = rd_word;
    if ((Bypass != 0) && collide) begin
      sample_word = merged_word;
    end
  end

  // Storage array: no reset, lane-granular writes.
  always_ff @(posedge clk) begin
    if (wr_active) begin
      for (int i = 0; i < Lanes; i++) begin
        if (we1[i]) begin
          mem[address1][i*LaneWidth +: LaneWidth] <= d1[i*LaneWidth +: LaneWidth];
        end
      end
    end
  end

  // Read pipeline and output register. The data sampled into stage 0 is a
  // private copy, so writes landing after the sampling edge cannot reach it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid <= '0;
      for (int s = 0; s < ReadLatency; s++) begin
        stage_data[s] <= '0;
      end
      q0       <= '0;
      q0_valid <= 1'b0;
    end else begin
      stage_valid[0] <= ce0;
      if (ce0) begin
        stage_data[0] <= sample_word;
      end
      for (int s = 1; s < ReadLatency; s++) begin
        stage_valid[s] <= stage_valid[s-1];
        if (stage_valid[s-1]) begin
          stage_data[s] <= stage_data[s-1];
        end
      end
      q0_valid <= stage_valid[ReadLatency-1];
      if (stage_valid[ReadLatency-1]) begin
        q0 <= stage_data[ReadLatency-1];
      end
    end
  end

endmodule

// File: tb/tb_knn_local_mem_1r1w_pipe.sv
// Bench for knn_local_mem_1r1w_pipe. Two instances share every input:
//   dut_a: ReadLatency=2, Bypass=0
//   dut_b: ReadLatency=4, Bypass=1
// both with AddressRange=2000. A behavioural model (word array plus a queue
// of pending read results tagged with their due cycle) predicts q0/q0_valid
// for each instance after every clock edge.
module tb_knn_local_mem_1r1w_pipe;

  localparam int DW = 256;
  localparam int AW = 11;
  localparam int AR = 2000;
  localparam int LW = 32;
  localparam int NL = DW / LW;
  localparam int LA = 2;
  localparam int LB = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address0;
  logic          ce0;
  logic [AW-1:0] address1;
  logic          ce1;
  logic [NL-1:0] we1;
  logic [DW-1:0] d1;
  logic [DW-1:0] q0_a, q0_b;
  logic          v_a, v_b;

  always #5 clk = ~clk;

  knn_local_mem_1r1w_pipe #(
    .DataWidth(DW), .AddressRange(AR), .AddressWidth(AW),
    .LaneWidth(LW), .ReadLatency(LA), .Bypass(0)
  ) dut_a (
    .clk(clk), .reset(reset), .address0(address0), .ce0(ce0),
    .q0(q0_a), .q0_valid(v_a), .address1(address1), .ce1(ce1),
    .we1(we1), .d1(d1)
  );

  knn_local_mem_1r1w_pipe #(
    .DataWidth(DW), .AddressRange(AR), .AddressWidth(AW),
    .LaneWidth(LW), .ReadLatency(LB), .Bypass(1)
  ) dut_b (
    .clk(clk), .reset(reset), .address0(address0), .ce0(ce0),
    .q0(q0_b), .q0_valid(v_b), .address1(address1), .ce1(ce1),
    .we1(we1), .d1(d1)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [2048];
  logic [DW-1:0] exp_qa[$];
  logic [DW-1:0] exp_qb[$];
  int            due_qa[$];
  int            due_qb[$];
  logic [DW-1:0] exp_o [2];
  logic          exp_v [2];
  int            cyc;
  int            n_checks;
  int            n_errors;

  localparam logic [DW-1:0] ALL_F  = {DW{1'b1}};
  localparam logic [DW-1:0] ALL_AA = {(DW/8){8'hAA}};
  localparam logic [DW-1:0] ALL_11 = {(DW/8){8'h11}};
  localparam logic [DW-1:0] LANE_EXP = {{(NL-1){32'hAAAAAAAA}}, 32'h11111111};

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // What a read issued with the current inputs returns under a given policy.
  function automatic logic [DW-1:0] model_read(input bit byp);
    logic [DW-1:0] v;
    if (int'(address0) >= AR) return '0;
    v = ref_mem[address0];
    if (byp && ce1 && (address1 == address0)) begin
      for (int i = 0; i < NL; i++)
        if (we1[i]) v[i*LW +: LW] = d1[i*LW +: LW];
    end
    return v;
  endfunction

  function automatic void model_clear();
    exp_qa.delete(); exp_qb.delete(); due_qa.delete(); due_qb.delete();
    exp_o[0] = '0; exp_o[1] = '0; exp_v[0] = 1'b0; exp_v[1] = 1'b0;
  endfunction

  // Driver: apply one cycle of inputs (starting at a negedge), update the
  // model for the coming edge, then return at the following negedge.
  task automatic step(input logic c0, input logic [AW-1:0] a0,
                      input logic c1, input logic [AW-1:0] a1,
                      input logic [NL-1:0] w, input logic [DW-1:0] d);
    ce0 = c0; address0 = a0; ce1 = c1; address1 = a1; we1 = w; d1 = d;
    if (!reset && c0) begin
      exp_qa.push_back(model_read(1'b0)); due_qa.push_back(cyc + 1 + LA);
      exp_qb.push_back(model_read(1'b1)); due_qb.push_back(cyc + 1 + LB);
    end
    if (!reset && c1 && int'(a1) < AR) begin
      for (int i = 0; i < NL; i++)
        if (w[i]) ref_mem[a1][i*LW +: LW] = d[i*LW +: LW];
    end
    @(posedge clk);
    cyc++;
    exp_v[0] = 1'b0;
    exp_v[1] = 1'b0;
    if (due_qa.size() > 0 && due_qa[0] == cyc) begin
      exp_v[0] = 1'b1; exp_o[0] = exp_qa.pop_front(); void'(due_qa.pop_front());
    end
    if (due_qb.size() > 0 && due_qb[0] == cyc) begin
      exp_v[1] = 1'b1; exp_o[1] = exp_qb.pop_front(); void'(due_qb.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; ce0 = 1'b0; ce1 = 1'b0; address0 = '0; address1 = '0;
    we1 = '0; d1 = '0; cyc = 0;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (q0_a !== '0 || v_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_a: q0=%h valid=%b, expected q0=0 valid=0", q0_a, v_a);
    end
    n_checks++;
    if (q0_b !== '0 || v_b !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_b: q0=%h valid=%b, expected q0=0 valid=0", q0_b, v_b);
    end
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lane_write();
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: step(1'b0, '0, 1'b1, 11'd5, '1, ALL_AA);
        1: step(1'b0, '0, 1'b1, 11'd5, 8'h01, ALL_11);
        2: step(1'b1, 11'd5, 1'b0, '0, '0, '0);
        default: idle();
      endcase
      n_checks++;
      if (q0_a !== exp_o[0] || v_a !== exp_v[0]) begin
        n_errors++;
        $display("FAIL lane_model_a s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_a, v_a, exp_o[0], exp_v[0]);
      end
      n_checks++;
      if (q0_b !== exp_o[1] || v_b !== exp_v[1]) begin
        n_errors++;
        $display("FAIL lane_model_b s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_b, v_b, exp_o[1], exp_v[1]);
      end
      if (s == 2 + LA) begin
        n_checks++;
        if (q0_a !== LANE_EXP || v_a !== 1'b1) begin
          n_errors++;
          $display("FAIL lane_value_a: q0=%h valid=%b, expected q0=%h valid=1", q0_a, v_a, LANE_EXP);
        end
      end
      if (s == 3 + LA) begin
        n_checks++;
        if (v_a !== 1'b0) begin
          n_errors++;
          $display("FAIL lane_strobe_width_a: valid=%b, expected 0", v_a);
        end
      end
      if (s == 2 + LB) begin
        n_checks++;
        if (q0_b !== LANE_EXP || v_b !== 1'b1) begin
          n_errors++;
          $display("FAIL lane_value_b: q0=%h valid=%b, expected q0=%h valid=1", q0_b, v_b, LANE_EXP);
        end
      end
    end
  endtask

  task automatic test_collision();
    for (int s = 0; s < 13; s++) begin
      case (s)
        0: step(1'b0, '0, 1'b1, 11'd7, '1, '0);
        1: step(1'b1, 11'd7, 1'b1, 11'd7, '1, ALL_F);
        7: step(1'b1, 11'd7, 1'b0, '0, '0, '0);
        default: idle();
      endcase
      n_checks++;
      if (q0_a !== exp_o[0] || v_a !== exp_v[0]) begin
        n_errors++;
        $display("FAIL coll_model_a s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_a, v_a, exp_o[0], exp_v[0]);
      end
      n_checks++;
      if (q0_b !== exp_o[1] || v_b !== exp_v[1]) begin
        n_errors++;
        $display("FAIL coll_model_b s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_b, v_b, exp_o[1], exp_v[1]);
      end
      if (s == 1 + LA) begin
        n_checks++;
        if (q0_a !== '0 || v_a !== 1'b1) begin
          n_errors++;
          $display("FAIL coll_old_data_a: q0=%h valid=%b, expected q0=0 valid=1", q0_a, v_a);
        end
      end
      if (s == 1 + LB) begin
        n_checks++;
        if (q0_b !== ALL_F || v_b !== 1'b1) begin
          n_errors++;
          $display("FAIL coll_new_data_b: q0=%h valid=%b, expected q0=%h valid=1", q0_b, v_b, ALL_F);
        end
      end
      if (s == 7 + LA) begin
        n_checks++;
        if (q0_a !== ALL_F || v_a !== 1'b1) begin
          n_errors++;
          $display("FAIL coll_reread_a: q0=%h valid=%b, expected q0=%h valid=1", q0_a, v_a, ALL_F);
        end
      end
      if (s == 7 + LB) begin
        n_checks++;
        if (q0_b !== ALL_F || v_b !== 1'b1) begin
          n_errors++;
          $display("FAIL coll_reread_b: q0=%h valid=%b, expected q0=%h valid=1", q0_b, v_b, ALL_F);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want;
    for (int s = 0; s < 38; s++) begin
      if (s < 16)      step(1'b0, '0, 1'b1, AW'(s), '1, DW'(s));
      else if (s < 32) step(1'b1, AW'(s - 16), 1'b0, '0, '0, '0);
      else             idle();
      n_checks++;
      if (q0_a !== exp_o[0] || v_a !== exp_v[0]) begin
        n_errors++;
        $display("FAIL stream_model_a s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_a, v_a, exp_o[0], exp_v[0]);
      end
      n_checks++;
      if (q0_b !== exp_o[1] || v_b !== exp_v[1]) begin
        n_errors++;
        $display("FAIL stream_model_b s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_b, v_b, exp_o[1], exp_v[1]);
      end
      if (s >= 16) begin
        // dut_b: strobes on 16 consecutive cycles starting LB after the first read
        n_checks++;
        if (s >= 16 + LB && s <= 31 + LB) begin
          want = DW'(s - 16 - LB);
          if (q0_b !== want || v_b !== 1'b1) begin
            n_errors++;
            $display("FAIL stream_b s=%0d: q0=%h valid=%b, expected q0=%h valid=1", s, q0_b, v_b, want);
          end
        end else if (v_b !== 1'b0) begin
          n_errors++;
          $display("FAIL stream_gap_b s=%0d: valid=%b, expected 0", s, v_b);
        end
      end
    end
    n_checks++;
    if (q0_b !== DW'(15) || q0_a !== DW'(15)) begin
      n_errors++;
      $display("FAIL stream_hold: q0_a=%h q0_b=%h, expected both 15", q0_a, q0_b);
    end
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] x;
    x = rnd_word();
    for (int s = 0; s < 18; s++) begin
      if (s == 4) begin
        reset = 1'b1;
        #1;
        n_checks++;
        if (q0_a !== '0 || v_a !== 1'b0 || q0_b !== '0 || v_b !== 1'b0) begin
          n_errors++;
          $display("FAIL midreset_outputs: q0_a=%h v_a=%b q0_b=%h v_b=%b, expected all 0", q0_a, v_a, q0_b, v_b);
        end
        model_clear();
      end
      if (s == 6) reset = 1'b0;
      case (s)
        0: step(1'b0, '0, 1'b1, 11'd3, '1, x);
        1, 2, 3, 12: step(1'b1, 11'd3, 1'b0, '0, '0, '0);
        default: idle();
      endcase
      n_checks++;
      if (q0_a !== exp_o[0] || v_a !== exp_v[0]) begin
        n_errors++;
        $display("FAIL midreset_model_a s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_a, v_a, exp_o[0], exp_v[0]);
      end
      n_checks++;
      if (q0_b !== exp_o[1] || v_b !== exp_v[1]) begin
        n_errors++;
        $display("FAIL midreset_model_b s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_b, v_b, exp_o[1], exp_v[1]);
      end
      if (s >= 4 && s <= 11) begin
        n_checks++;
        if (v_a !== 1'b0 || v_b !== 1'b0) begin
          n_errors++;
          $display("FAIL midreset_no_strobe s=%0d: v_a=%b v_b=%b, expected 0 0", s, v_a, v_b);
        end
      end
      if (s == 12 + LB) begin
        n_checks++;
        if (q0_b !== x || v_b !== 1'b1) begin
          n_errors++;
          $display("FAIL midreset_data_kept: q0=%h valid=%b, expected q0=%h valid=1", q0_b, v_b, x);
        end
      end
    end
  endtask

  task automatic test_boundary();
    logic [DW-1:0] p, q, r;
    logic [DW-1:0] bexp [5];
    p = rnd_word(); q = rnd_word(); r = rnd_word();
    bexp[0] = p; bexp[1] = '0; bexp[2] = r; bexp[3] = r; bexp[4] = '0;
    for (int s = 0; s < 15; s++) begin
      case (s)
        0: step(1'b0, '0, 1'b1, 11'd1999, '1, p);
        1: step(1'b0, '0, 1'b1, 11'd976, '1, r);
        2: step(1'b0, '0, 1'b1, 11'd464, '1, r);
        3: step(1'b0, '0, 1'b1, 11'd2000, '1, q);
        4: step(1'b0, '0, 1'b1, 11'd2047, '1, q);
        5: step(1'b1, 11'd1999, 1'b0, '0, '0, '0);
        6: step(1'b1, 11'd2000, 1'b0, '0, '0, '0);
        7: step(1'b1, 11'd976, 1'b0, '0, '0, '0);
        8: step(1'b1, 11'd464, 1'b0, '0, '0, '0);
        9: step(1'b1, 11'd2047, 1'b0, '0, '0, '0);
        default: idle();
      endcase
      n_checks++;
      if (q0_a !== exp_o[0] || v_a !== exp_v[0]) begin
        n_errors++;
        $display("FAIL bound_model_a s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_a, v_a, exp_o[0], exp_v[0]);
      end
      n_checks++;
      if (q0_b !== exp_o[1] || v_b !== exp_v[1]) begin
        n_errors++;
        $display("FAIL bound_model_b s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_b, v_b, exp_o[1], exp_v[1]);
      end
      if (s >= 5 + LA && s <= 9 + LA) begin
        n_checks++;
        if (q0_a !== bexp[s-5-LA] || v_a !== 1'b1) begin
          n_errors++;
          $display("FAIL bound_a read%0d: q0=%h valid=%b, expected q0=%h valid=1", s - 5 - LA, q0_a, v_a, bexp[s-5-LA]);
        end
      end
    end
  endtask

  task automatic test_write_after_sample();
    logic [DW-1:0] a, b;
    a = rnd_word(); b = ~a;
    for (int s = 0; s < 14; s++) begin
      case (s)
        0: step(1'b0, '0, 1'b1, 11'd9, '1, a);
        1, 8: step(1'b1, 11'd9, 1'b0, '0, '0, '0);
        2: step(1'b0, '0, 1'b1, 11'd9, '1, b);
        default: idle();
      endcase
      n_checks++;
      if (q0_a !== exp_o[0] || v_a !== exp_v[0]) begin
        n_errors++;
        $display("FAIL late_model_a s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_a, v_a, exp_o[0], exp_v[0]);
      end
      n_checks++;
      if (q0_b !== exp_o[1] || v_b !== exp_v[1]) begin
        n_errors++;
        $display("FAIL late_model_b s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_b, v_b, exp_o[1], exp_v[1]);
      end
      if (s == 1 + LB) begin
        n_checks++;
        if (q0_b !== a) begin
          n_errors++;
          $display("FAIL late_inflight_b: q0=%h, expected old %h", q0_b, a);
        end
      end
      if (s == 8 + LA) begin
        n_checks++;
        if (q0_a !== b) begin
          n_errors++;
          $display("FAIL late_reread_a: q0=%h, expected new %h", q0_a, b);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] ra0, ra1;
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, AW'(i), '1, rnd_word());
    for (int i = 1990; i < 2000; i++) step(1'b0, '0, 1'b1, AW'(i), '1, rnd_word());
    for (int s = 0; s < 306; s++) begin
      if (s < 300) begin
        ra0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(1990, 2047)) : AW'($urandom_range(0, 15));
        ra1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(1990, 2047)) : AW'($urandom_range(0, 15));
        step(1'($urandom_range(0, 3) != 0), ra0, 1'($urandom_range(0, 1)), ra1,
             NL'($urandom), rnd_word());
      end else begin
        idle();
      end
      n_checks++;
      if (q0_a !== exp_o[0] || v_a !== exp_v[0]) begin
        n_errors++;
        $display("FAIL rand_model_a s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_a, v_a, exp_o[0], exp_v[0]);
      end
      n_checks++;
      if (q0_b !== exp_o[1] || v_b !== exp_v[1]) begin
        n_errors++;
        $display("FAIL rand_model_b s=%0d: q0=%h valid=%b, expected q0=%h valid=%b", s, q0_b, v_b, exp_o[1], exp_v[1]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_lane_write();
    test_collision();
    test_back_to_back();
    test_reset_midflight();
    test_boundary();
    test_write_after_sample();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/knn_local_mem_1r1w_pipe.md
# knn_local_mem_1r1w_pipe

Parametrised simple-dual-port local buffer for the partialKnn kernels. It replaces the single-port, fixed-latency URAM wrapper with three additions: a dedicated read port and write port, a configurable read pipeline depth, and per-lane write enables. It also provides a defined read/write collision policy and a read-data valid strobe. It sits between a kernel's load/compute stages and its on-chip search-point storage.

## Interface
- `DataWidth`, 256, word width in bits.
- `AddressRange`, 2048, number of words.
- `AddressWidth`, 11, address bits; must satisfy 2^AddressWidth >= AddressRange.
- `LaneWidth`, 32, bits per write-enable lane; DataWidth must be a multiple of LaneWidth.
- `ReadLatency`, 2, cycles from read request to data; legal range 1..4.
- `Bypass`, 0, collision policy: 0 returns old data, 1 returns new (merged) data.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `address0`  in  AddressWidth  read address.
- `ce0`  in  1  read request.
- `q0`  out  DataWidth  read data.
- `q0_valid`  out  1  one-cycle strobe marking new `q0` data.
- `address1`  in  AddressWidth  write address.
- `ce1`  in  1  write port enable.
- `we1`  in  DataWidth/LaneWidth  per-lane write enable; lane i covers bits [i*LaneWidth +: LaneWidth].
- `d1`  in  DataWidth  write data.

## Operation
- **Write:** on a rising `clk` edge with `ce1`=1, each lane i with `we1[i]`=1 is written from `d1`. Other lanes keep their contents.
  - `ce1`=1 with `we1`=0 is a no-op.
- **Read:** on a rising edge with `ce0`=1, the array word at `address0` is sampled into pipeline stage 1.
  - The request then advances one stage per cycle through ReadLatency stages, each stage carrying data plus a valid bit.
  - `q0` is driven from the final stage.
- **Collision** (same edge, `ce0`=`ce1`=1, `address0`==`address1`):
  - `Bypass`=0: the read returns the pre-write word.
  - `Bypass`=1: the read returns the post-write word. Lanes with `we1` set take `d1`; the remaining lanes keep old data.
  - The write always takes effect.
- **Later writes:** a write that lands after a read has been sampled never alters that in-flight read.
- **Out of range** (address >= AddressRange):
  - A write is ignored.
  - A read completes normally with `q0`=0 and `q0_valid`=1.
- **Output hold:** `q0` holds its last value until the next completing read. `q0_valid` is 1 only in the cycle new data appears.
- **Reset:**
  - `q0`=0, `q0_valid`=0, and all pipeline valid bits cleared. In-flight reads are discarded with no strobe after reset release.
  - Array contents are not reset, and writes are blocked while `reset`=1.
- **Throughput:** one read and one write per cycle, with no stalls and no backpressure. The consumer must accept every `q0_valid` strobe.

## Timing
- Read issued at edge t → `q0`/`q0_valid` update at edge t+ReadLatency.
  - ReadLatency=1 matches the legacy wrapper's latency.
- Back-to-back reads at edges t, t+1, t+2 → strobes at t+L, t+L+1, t+L+2 with matching data and no gaps.
- A write at edge t is visible to a non-colliding read issued at edge t+1 or later.
- Asynchronous reset acts immediately on all outputs and pipeline valid bits. Deassertion is synchronous to `clk` by the system reset tree.

## Test plan
- **Lane write, then read** (ReadLatency=2, LaneWidth=32):
  - Write 0xAA..AA to address 5 with all lanes set.
  - Then write `d1`=0x11..11 with `we1`=8'b0000_0001.
  - Read address 5 → two cycles later `q0`=0xAA..AA11111111 and `q0_valid` high for 1 cycle.
- **Collision, both policies:** address 7 holds 0x0; same-edge write 0xFF..FF plus read of address 7.
  - `Bypass`=0 → `q0`=0.
  - `Bypass`=1 → `q0`=0xFF..FF.
  - A re-read returns 0xFF..FF in both cases.
- **Streaming reads, ReadLatency=4:** 16 consecutive reads of addresses 0..15 (preloaded with their index).
  - `q0_valid` high for 16 consecutive cycles starting 4 cycles after the first request.
  - `q0` = 0..15 in order; `q0` then holds 15.
- **Reset mid-flight:** issue 3 reads, then assert `reset` one cycle later.
  - `q0`=0 and `q0_valid`=0 immediately.
  - No strobe after release.
  - Array data written before reset is still readable.
- **Boundary addresses** (AddressRange=2000):
  - Write and read address 1999 → data round-trips.
  - Write to address 2000 is ignored, and no alias appears at address 2000 mod anything.
  - Read of address 2047 → `q0`=0 with the strobe.
- **Write lands after sampling:** read address 9 at edge t, then write address 9 at edge t+1 → the in-flight read returns the old value.
